// File: rtl/synth_pkg.sv
// Types and helpers shared by the synth control blocks.
// The gate FSM encoding is fixed so that other blocks can decode the state.
package synth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GATE_ON = 2'b01,
        ST_RETRIG  = 2'b10
    } gate_state_e;

    localparam int unsigned NKEYS_DEF      = 8;
    localparam int unsigned NBIT_NOTE_DEF  = 3;
    localparam int unsigned DEB_DIV_DEF    = 50000;
    localparam int unsigned DEB_TICKS_DEF  = 4;
    localparam int unsigned RETRIG_CYC_DEF = 2;

    // Counter width that holds 0..n-1 with one bit of headroom.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

    // Width of a free-running divider counting 0..n-1; never zero.
    function automatic int unsigned div_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_gate_ctrl_debounce.sv
// Single-key synchroniser and tick-sampled debouncer.
// The debounced state only flips after DEB_TICKS consecutive disagreeing ticks.
module key_debounce
    import synth_pkg::*;
#(
    parameter int unsigned DEB_TICKS = DEB_TICKS_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic tick,
    input  logic raw,
    output logic state
);

    localparam int unsigned CW = cnt_width(DEB_TICKS);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser for the asynchronous key level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Any tick that agrees with the current state discards partial evidence.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= 1'b0;
            cnt   <= '0;
        end else if (tick) begin
            if (sync_2 == state) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_TICKS - 1)) begin
                state <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_gate_ctrl.sv
// Key scanner front-end for the ADSR envelope: debounced keys, last-note priority,
// legato fallback on release, and a forced gate-low gap on retrigger.
module key_gate_ctrl
    import synth_pkg::*;
#(
    parameter int unsigned NKEYS      = NKEYS_DEF,
    parameter int unsigned NBIT_NOTE  = NBIT_NOTE_DEF,
    parameter int unsigned DEB_DIV    = DEB_DIV_DEF,
    parameter int unsigned DEB_TICKS  = DEB_TICKS_DEF,
    parameter int unsigned RETRIG_CYC = RETRIG_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NKEYS-1:0]     keys_in,
    output logic                 gate_out,
    output logic [NBIT_NOTE-1:0] note_idx,
    output logic [NKEYS-1:0]     keys_db
);

    localparam int unsigned DIV_W = div_width(DEB_DIV);
    localparam int unsigned RCW   = cnt_width(RETRIG_CYC);

    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic [NKEYS-1:0]     keys_db_d;
    logic [NKEYS-1:0]     press;
    logic [NKEYS-1:0]     rel_edge;
    logic                 any_press;
    logic                 any_held;
    logic                 cur_released;
    logic [NBIT_NOTE-1:0] press_pick;
    logic [NBIT_NOTE-1:0] held_pick;
    logic [RCW-1:0]       rcnt;
    gate_state_e          state;

    // Shared debounce sample tick.
    assign tick = (div_cnt == DIV_W'(DEB_DIV - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    for (genvar k = 0; k < NKEYS; k++) begin : g_key
        key_debounce #(
            .DEB_TICKS (DEB_TICKS)
        ) u_deb (
            .clk   (clk),
            .rstn  (rstn),
            .tick  (tick),
            .raw   (keys_in[k]),
            .state (keys_db[k])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            keys_db_d <= '0;
        end else begin
            keys_db_d <= keys_db;
        end
    end

    assign press     = keys_db & ~keys_db_d;
    assign rel_edge  = ~keys_db & keys_db_d;
    assign any_press = |press;
    assign any_held  = |keys_db;

    // Ascending scan leaves the highest matching index in each pick.
    always_comb begin
        press_pick   = '0;
        held_pick    = '0;
        cur_released = 1'b0;
        for (int k = 0; k < NKEYS; k++) begin
            if (press[k]) begin
                press_pick = NBIT_NOTE'(k);
            end
            if (keys_db[k]) begin
                held_pick = NBIT_NOTE'(k);
            end
            if (rel_edge[k] && (note_idx == NBIT_NOTE'(k))) begin
                cur_released = 1'b1;
            end
        end
    end

    // Gate FSM; all-released beats press beats legato fallback.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            gate_out <= 1'b0;
            note_idx <= '0;
            rcnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    gate_out <= 1'b0;
                    if (any_press) begin
                        note_idx <= press_pick;
                        state    <= ST_GATE_ON;
                        gate_out <= 1'b1;
                    end
                end
                ST_GATE_ON: begin
                    gate_out <= 1'b1;
                    if (!any_held) begin
                        state    <= ST_IDLE;
                        gate_out <= 1'b0;
                    end else if (any_press) begin
                        note_idx <= press_pick;
                        rcnt     <= '0;
                        state    <= ST_RETRIG;
                        gate_out <= 1'b0;
                    end else if (cur_released) begin
                        note_idx <= held_pick;
                    end
                end
                ST_RETRIG: begin
                    gate_out <= 1'b0;
                    if (!any_held) begin
                        state <= ST_IDLE;
                    end else if (any_press) begin
                        note_idx <= press_pick;
                        rcnt     <= '0;
                    end else if (rcnt == RCW'(RETRIG_CYC - 1)) begin
                        state    <= ST_GATE_ON;
                        gate_out <= 1'b1;
                    end else begin
                        rcnt <= rcnt + RCW'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    gate_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_gate_ctrl.sv
// Directed self-checking bench for key_gate_ctrl with a short debounce period.
module tb_key_gate_ctrl;

    localparam int unsigned NKEYS      = 8;
    localparam int unsigned NBIT_NOTE  = 3;
    localparam int unsigned DEB_DIV    = 4;
    localparam int unsigned DEB_TICKS  = 3;
    localparam int unsigned RETRIG_CYC = 2;

    logic                 clk;
    logic                 rstn;
    logic [NKEYS-1:0]     keys_in;
    logic                 gate_out;
    logic [NBIT_NOTE-1:0] note_idx;
    logic [NKEYS-1:0]     keys_db;

    int total;
    int bad;

    key_gate_ctrl #(
        .NKEYS      (NKEYS),
        .NBIT_NOTE  (NBIT_NOTE),
        .DEB_DIV    (DEB_DIV),
        .DEB_TICKS  (DEB_TICKS),
        .RETRIG_CYC (RETRIG_CYC)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .keys_in  (keys_in),
        .gate_out (gate_out),
        .note_idx (note_idx),
        .keys_db  (keys_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bounded wait for gate_out to reach a level, sampled on falling edges.
    task automatic wait_gate(input logic val, input int budget, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (gate_out === val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn    = 1'b0;
        keys_in = '0;
        repeat (3) @(negedge clk);
        total++;
        if (gate_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_gate: got %b want 0", gate_out);
        end
        total++;
        if (note_idx !== 3'd0) begin
            bad++;
            $display("FAIL reset_note: got %0d want 0", note_idx);
        end
        total++;
        if (keys_db !== 8'h00) begin
            bad++;
            $display("FAIL reset_keys_db: got %h want 00", keys_db);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_key();
        int cyc;
        bit ok;
        keys_in = 8'b0000_1000;
        wait_gate(1'b1, 16, cyc, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL single_gate_on: gate=%b after %0d cycles, want 1", gate_out, cyc);
        end
        total++;
        if (note_idx !== 3'd3) begin
            bad++;
            $display("FAIL single_note: got %0d want 3", note_idx);
        end
        keys_in = '0;
        wait_gate(1'b0, 16, cyc, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL single_gate_off: gate=%b after %0d cycles, want 0", gate_out, cyc);
        end
        total++;
        if (note_idx !== 3'd3) begin
            bad++;
            $display("FAIL single_note_tail: got %0d want 3", note_idx);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_glitch();
        bit seen_db;
        bit seen_gate;
        seen_db   = 1'b0;
        seen_gate = 1'b0;
        keys_in   = 8'b0000_0010;
        repeat (5) begin
            @(negedge clk);
            if (keys_db !== 8'h00) seen_db = 1'b1;
            if (gate_out !== 1'b0) seen_gate = 1'b1;
        end
        keys_in = '0;
        repeat (30) begin
            @(negedge clk);
            if (keys_db !== 8'h00) seen_db = 1'b1;
            if (gate_out !== 1'b0) seen_gate = 1'b1;
        end
        total++;
        if (seen_db !== 1'b0) begin
            bad++;
            $display("FAIL glitch_keys_db: changed=%b want 0", seen_db);
        end
        total++;
        if (seen_gate !== 1'b0) begin
            bad++;
            $display("FAIL glitch_gate: changed=%b want 0", seen_gate);
        end
    endtask

    task automatic test_retrig_legato();
        int cyc;
        int low;
        bit ok;
        bit dip;
        keys_in = 8'b0000_0100;
        wait_gate(1'b1, 16, cyc, ok);
        total++;
        if (ok !== 1'b1 || note_idx !== 3'd2) begin
            bad++;
            $display("FAIL retrig_first: ok=%b note=%0d want ok=1 note=2", ok, note_idx);
        end
        repeat (3) @(negedge clk);
        keys_in = 8'b0010_0100;
        wait_gate(1'b0, 20, cyc, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL retrig_gap_start: gate=%b after %0d cycles, want 0", gate_out, cyc);
        end
        low = 1;
        while (low < 20) begin
            @(negedge clk);
            if (gate_out !== 1'b0) break;
            low++;
        end
        total++;
        if (low !== 2) begin
            bad++;
            $display("FAIL retrig_gap_len: got %0d want 2", low);
        end
        total++;
        if (note_idx !== 3'd5) begin
            bad++;
            $display("FAIL retrig_note: got %0d want 5", note_idx);
        end
        keys_in = 8'b0000_0100;
        dip = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (gate_out !== 1'b1) dip = 1'b1;
        end
        total++;
        if (dip !== 1'b0) begin
            bad++;
            $display("FAIL legato_no_dip: dip=%b want 0", dip);
        end
        total++;
        if (note_idx !== 3'd2) begin
            bad++;
            $display("FAIL legato_note: got %0d want 2", note_idx);
        end
        keys_in = '0;
        wait_gate(1'b0, 16, cyc, ok);
        total++;
        if (ok !== 1'b1 || note_idx !== 3'd2) begin
            bad++;
            $display("FAIL legato_off: ok=%b note=%0d want ok=1 note=2", ok, note_idx);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int cyc;
        bit ok;
        keys_in = 8'b0100_0010;
        wait_gate(1'b1, 16, cyc, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL simul_gate: gate=%b after %0d cycles, want 1", gate_out, cyc);
        end
        total++;
        if (note_idx !== 3'd6) begin
            bad++;
            $display("FAIL simul_note: got %0d want 6", note_idx);
        end
        total++;
        if (keys_db !== 8'h42) begin
            bad++;
            $display("FAIL simul_keys_db: got %h want 42", keys_db);
        end
        keys_in = '0;
        wait_gate(1'b0, 16, cyc, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL simul_off: gate=%b after %0d cycles, want 0", gate_out, cyc);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_async_reset();
        int cyc;
        bit ok;
        keys_in = 8'b0000_1000;
        wait_gate(1'b1, 16, cyc, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL areset_pre_gate: gate=%b want 1", gate_out);
        end
        #2;
        rstn = 1'b0;
        #1;
        total++;
        if (gate_out !== 1'b0 || note_idx !== 3'd0 || keys_db !== 8'h00) begin
            bad++;
            $display("FAIL areset_immediate: gate=%b note=%0d db=%h want 0 0 00",
                     gate_out, note_idx, keys_db);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        wait_gate(1'b1, 18, cyc, ok);
        total++;
        if (ok !== 1'b1 || note_idx !== 3'd3) begin
            bad++;
            $display("FAIL areset_regate: ok=%b note=%0d want ok=1 note=3", ok, note_idx);
        end
        keys_in = '0;
        wait_gate(1'b0, 16, cyc, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL areset_off: gate=%b want 0", gate_out);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rstn    = 1'b0;
        keys_in = '0;
        test_reset();
        test_single_key();
        test_glitch();
        test_retrig_legato();
        test_simultaneous();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
